// File: rtl/mac_array_pkg.sv
// rtl/mac_array_pkg.sv - opcodes, FSM encoding and saturation helper for mac_array_ci
package mac_array_pkg;

  localparam logic [2:0] OP_MAC     = 3'd0;
  localparam logic [2:0] OP_READ    = 3'd1;
  localparam logic [2:0] OP_CLEAR   = 3'd2;
  localparam logic [2:0] OP_READCLR = 3'd3;
  localparam logic [2:0] OP_DOT     = 3'd4;
  localparam logic [2:0] OP_WRITE   = 3'd5;

  // Widest accumulator the saturation helper accepts; callers sign-extend into it.
  localparam int ACC_W_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_S1,
    ST_S2,
    ST_DONE
  } state_t;

  // Clamp a signed value to the 32-bit signed range.
  function automatic logic [31:0] sat32(input logic signed [ACC_W_MAX-1:0] x);
    if (x > 64'sh0000_0000_7FFF_FFFF) begin
      return 32'h7FFF_FFFF;
    end else if (x < 64'shFFFF_FFFF_8000_0000) begin
      return 32'h8000_0000;
    end else begin
      return x[31:0];
    end
  endfunction

endpackage

// File: rtl/mac_dot_lanes.sv
// rtl/mac_dot_lanes.sv - packed-lane signed multipliers and adder tree, two register stages
module mac_dot_lanes #(
  parameter int DATA_W = 8,
  parameter int LANES  = 32 / DATA_W,
  parameter int DOT_W  = 2 * DATA_W + $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    load,
  input  logic [31:0]             dataa,
  input  logic [31:0]             datab,
  output logic signed [DOT_W-1:0] dot
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod [LANES];
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic signed [DOT_W-1:0]  sum;

  // Unpack lanes and form full-width signed products.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      logic signed [DATA_W-1:0] a_lane;
      logic signed [DATA_W-1:0] b_lane;
      a_lane  = dataa[i*DATA_W +: DATA_W];
      b_lane  = datab[i*DATA_W +: DATA_W];
      prod[i] = PROD_W'(a_lane) * PROD_W'(b_lane);
    end
  end

  // Stage 1: capture products only when an instruction is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else if (clk_en && load) begin
      for (int i = 0; i < LANES; i++) prod_q[i] <= prod[i];
    end
  end

  // Reduce the registered products; DOT_W leaves headroom for every lane at full scale.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + DOT_W'(prod_q[i]);
    end
  end

  // Stage 2: register the reduced sum each enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dot <= '0;
    end else if (clk_en) begin
      dot <= sum;
    end
  end

endmodule

// File: rtl/mac_array_ci.sv
// rtl/mac_array_ci.sv - multi-cycle dot-product custom instruction with banked accumulators
module mac_array_ci
  import mac_array_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LANES    = 32 / DATA_W,
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [7:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);

  localparam int DOT_W = 2 * DATA_W + $clog2(LANES);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t state;
  state_t state_next;

  logic                    accept;
  logic [2:0]              op_q;
  logic [CH_W-1:0]         ch_q;
  logic [31:0]             wdata_q;
  logic signed [DOT_W-1:0] dot;
  logic signed [ACC_W-1:0] acc [CHANNELS];

  logic signed [ACC_W-1:0]     acc_sel;
  logic signed [ACC_W-1:0]     dot_acc;
  logic signed [ACC_W-1:0]     wdata_acc;
  logic signed [ACC_W_MAX-1:0] acc_wide;
  logic signed [ACC_W_MAX-1:0] dot_wide;

  // Channel bits above CH_W are deliberately ignored.
  logic unused_n;
  assign unused_n = ^n;

  assign accept = (state == ST_IDLE) && start;
  assign done   = (state == ST_DONE);

  mac_dot_lanes #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .DOT_W  (DOT_W)
  ) u_dot (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .load   (accept),
    .dataa  (dataa),
    .datab  (datab),
    .dot    (dot)
  );

  // FSM state register; clk_en low holds the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  // Fixed four-step sequence; start is only honoured in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_S1;
      ST_S1:   state_next = ST_S2;
      ST_S2:   state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Latch opcode, channel and preload word at accept time.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      ch_q    <= '0;
      wdata_q <= '0;
    end else if (clk_en && accept) begin
      op_q    <= n[2:0];
      ch_q    <= n[3 +: CH_W];
      wdata_q <= dataa;
    end
  end

  // Operand views sign-extended to accumulator and saturation widths.
  always_comb begin
    acc_sel   = acc[ch_q];
    dot_acc   = ACC_W'(dot);
    wdata_acc = ACC_W'($signed(wdata_q));
    acc_wide  = ACC_W_MAX'(acc_sel);
    dot_wide  = ACC_W_MAX'(dot);
  end

  // Accumulator bank and result register update on the S2 -> DONE edge only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
      result <= '0;
    end else if (clk_en && state == ST_S2) begin
      result <= '0;
      case (op_q)
        OP_MAC:     acc[ch_q] <= acc_sel + dot_acc;
        OP_READ:    result <= sat32(acc_wide);
        OP_CLEAR:   acc[ch_q] <= '0;
        OP_READCLR: begin
          result    <= sat32(acc_wide);
          acc[ch_q] <= '0;
        end
        OP_DOT:     result <= sat32(dot_wide);
        OP_WRITE:   acc[ch_q] <= wdata_acc;
        default:    result <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_array_ci.sv
// tb/tb_mac_array_ci.sv - directed self-checking bench for mac_array_ci
module tb_mac_array_ci;
  import mac_array_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [7:0]  n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        done;
  logic [31:0] result;
  logic        done16;
  logic [31:0] result16;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] res;
  int          lat;

  localparam logic [31:0] A10 = 32'h0102_0304;
  localparam logic [31:0] B10 = 32'h0101_0101;
  localparam logic [31:0] AN  = 32'hFFFF_FFFF;
  localparam logic [31:0] BN  = 32'h7F7F_7F7F;

  mac_array_ci #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .done(done), .result(result)
  );

  mac_array_ci #(.DATA_W(16)) dut16 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .done(done16), .result(result16)
  );

  always #5 clk = ~clk;

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic issue(input logic [2:0] op, input int ch, input logic [31:0] a,
                       input logic [31:0] b, input int stall_len, input bit spurious,
                       output logic [31:0] r, output int l);
    int cnt;
    logic [4:0] chf;
    chf   = ch[4:0];
    n     = {chf, op};
    dataa = a;
    datab = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 1;
    l     = -1;
    while (cnt <= 40) begin
      if (done) begin
        l = cnt;
        break;
      end
      if (spurious && cnt == 1) begin
        start = 1'b1;
        n     = {chf, OP_WRITE};
        dataa = 32'h1234_5678;
      end else begin
        start = 1'b0;
      end
      if (stall_len > 0 && cnt == 1) clk_en = 1'b0;
      if (stall_len > 0 && cnt == 1 + stall_len) clk_en = 1'b1;
      @(negedge clk);
      cnt++;
    end
    start  = 1'b0;
    clk_en = 1'b1;
    r      = result;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse_width: done=%b after completion, required 0", done);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    n      = '0;
    dataa  = '0;
    datab  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (done !== 1'b0 || result !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: done=%b result=%h, required 0 and 00000000", done, result);
    end
    for (int c = 0; c < 4; c++) begin
      issue(OP_READ, c, 32'h0, 32'h0, 0, 1'b0, res, lat);
      n_cmp++;
      if (res !== 32'h0 || lat !== 3) begin
        n_bad++;
        $display("FAIL reset_acc_ch%0d: result=%h latency=%0d, required 00000000 and 3", c, res, lat);
      end
    end
  endtask

  task automatic test_dot();
    issue(OP_DOT, 0, AN, BN, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'hFFFF_FE04 || lat !== 3) begin
      n_bad++;
      $display("FAIL dot_neg: result=%h latency=%0d, required fffffe04 and 3", res, lat);
    end
    n_cmp++;
    if (result16 !== 32'hFFFF_0102) begin
      n_bad++;
      $display("FAIL dot_neg_w16: result=%h, required ffff0102", result16);
    end
    for (int c = 0; c < 4; c++) begin
      issue(OP_READ, c, 32'h0, 32'h0, 0, 1'b0, res, lat);
      n_cmp++;
      if (res !== 32'h0) begin
        n_bad++;
        $display("FAIL dot_no_acc_ch%0d: result=%h, required 00000000", c, res);
      end
    end
  endtask

  task automatic test_mac_read();
    for (int k = 0; k < 2; k++) begin
      issue(OP_MAC, 0, A10, B10, 0, 1'b0, res, lat);
      n_cmp++;
      if (res !== 32'h0 || lat !== 3) begin
        n_bad++;
        $display("FAIL mac_ch0_%0d: result=%h latency=%0d, required 00000000 and 3", k, res, lat);
      end
    end
    issue(OP_READ, 0, 32'h0, 32'h0, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'd20) begin
      n_bad++;
      $display("FAIL read_ch0: result=%h, required 00000014", res);
    end
  endtask

  task automatic test_saturate();
    issue(OP_WRITE, 2, 32'h7FFF_FFF0, 32'h0, 0, 1'b0, res, lat);
    issue(OP_MAC, 2, A10, B10, 0, 1'b0, res, lat);
    issue(OP_MAC, 2, A10, B10, 0, 1'b0, res, lat);
    issue(OP_READ, 2, 32'h0, 32'h0, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'h7FFF_FFFF) begin
      n_bad++;
      $display("FAIL sat_pos_read: result=%h, required 7fffffff", res);
    end
    issue(OP_READCLR, 2, 32'h0, 32'h0, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'h7FFF_FFFF) begin
      n_bad++;
      $display("FAIL sat_pos_readclr: result=%h, required 7fffffff", res);
    end
    issue(OP_READ, 2, 32'h0, 32'h0, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'h0) begin
      n_bad++;
      $display("FAIL readclr_cleared: result=%h, required 00000000", res);
    end
    issue(OP_WRITE, 3, 32'h8000_0000, 32'h0, 0, 1'b0, res, lat);
    issue(OP_MAC, 3, AN, BN, 0, 1'b0, res, lat);
    issue(OP_READ, 3, 32'h0, 32'h0, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL sat_neg_read: result=%h, required 80000000", res);
    end
    issue(OP_CLEAR, 3, 32'h0, 32'h0, 0, 1'b0, res, lat);
    issue(OP_READ, 3, 32'h0, 32'h0, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'h0) begin
      n_bad++;
      $display("FAIL clear_ch3: result=%h, required 00000000", res);
    end
  endtask

  task automatic test_channels();
    issue(OP_MAC, 1, A10, B10, 0, 1'b0, res, lat);
    issue(OP_MAC, 1, A10, B10, 0, 1'b0, res, lat);
    issue(OP_MAC, 3, AN, BN, 0, 1'b0, res, lat);
    issue(OP_READ, 1, 32'h0, 32'h0, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'd20) begin
      n_bad++;
      $display("FAIL iso_ch1: result=%h, required 00000014", res);
    end
    issue(OP_READ, 3, 32'h0, 32'h0, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'hFFFF_FE04) begin
      n_bad++;
      $display("FAIL iso_ch3: result=%h, required fffffe04", res);
    end
    issue(OP_READ, 0, 32'h0, 32'h0, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'd20) begin
      n_bad++;
      $display("FAIL iso_ch0: result=%h, required 00000014", res);
    end
    issue(OP_READ, 2, 32'h0, 32'h0, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'h0) begin
      n_bad++;
      $display("FAIL iso_ch2: result=%h, required 00000000", res);
    end
  endtask

  task automatic test_stall();
    issue(OP_MAC, 1, A10, B10, 5, 1'b0, res, lat);
    n_cmp++;
    if (lat !== 8 || res !== 32'h0) begin
      n_bad++;
      $display("FAIL stall_mac: latency=%0d result=%h, required 8 and 00000000", lat, res);
    end
    issue(OP_READ, 1, 32'h0, 32'h0, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'd30) begin
      n_bad++;
      $display("FAIL stall_read_ch1: result=%h, required 0000001e", res);
    end
  endtask

  task automatic test_start_ignored();
    issue(OP_MAC, 1, A10, B10, 0, 1'b1, res, lat);
    n_cmp++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL busy_start_latency: latency=%0d, required 3", lat);
    end
    issue(OP_READ, 1, 32'h0, 32'h0, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'd40) begin
      n_bad++;
      $display("FAIL busy_start_ignored: result=%h, required 00000028", res);
    end
  endtask

  task automatic test_unused_ops();
    issue(3'd6, 1, A10, B10, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'h0 || lat !== 3) begin
      n_bad++;
      $display("FAIL op6: result=%h latency=%0d, required 00000000 and 3", res, lat);
    end
    issue(OP_READ, 5, 32'h0, 32'h0, 0, 1'b0, res, lat);
    issue(3'd7, 1, A10, B10, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'h0 || lat !== 3) begin
      n_bad++;
      $display("FAIL op7: result=%h latency=%0d, required 00000000 and 3", res, lat);
    end
    issue(OP_READ, 5, 32'h0, 32'h0, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'd40) begin
      n_bad++;
      $display("FAIL ch_upper_bits: result=%h, required 00000028", res);
    end
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    saw_done = 1'b0;
    n     = {5'd0, OP_MAC};
    dataa = A10;
    datab = B10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (saw_done !== 1'b0 || result !== 32'h0) begin
      n_bad++;
      $display("FAIL abort_no_done: saw_done=%b result=%h, required 0 and 00000000", saw_done, result);
    end
    n     = {5'd0, OP_WRITE};
    dataa = 32'h0000_0055;
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_bad++;
      $display("FAIL start_with_reset: saw_done=%b, required 0", saw_done);
    end
    issue(OP_READ, 0, 32'h0, 32'h0, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'h0) begin
      n_bad++;
      $display("FAIL abort_ch0: result=%h, required 00000000", res);
    end
    issue(OP_READ, 1, 32'h0, 32'h0, 0, 1'b0, res, lat);
    n_cmp++;
    if (res !== 32'h0) begin
      n_bad++;
      $display("FAIL abort_ch1: result=%h, required 00000000", res);
    end
  endtask

  task automatic test_dot16();
    issue(OP_DOT, 0, 32'h0003_0002, 32'h0004_0005, 0, 1'b0, res, lat);
    n_cmp++;
    if (result16 !== 32'd22) begin
      n_bad++;
      $display("FAIL dot_w16: result=%h, required 00000016", result16);
    end
    n_cmp++;
    if (res !== 32'd22) begin
      n_bad++;
      $display("FAIL dot_w8_same_ops: result=%h, required 00000016", res);
    end
  endtask

  initial begin
    test_reset();
    test_dot();
    test_mac_read();
    test_saturate();
    test_channels();
    test_stall();
    test_start_ignored();
    test_unused_ops();
    test_reset_abort();
    test_dot16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
